// File: rtl/gate_sweep_ctrl.sv
// Sequencer that sweeps the six two-input primitive gates through all four input vectors
// and checks each result against a built-in truth table. Optional: GATE_SWEEP_STOP_ON_FAIL_EN.
module gate_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       c,
  output logic [2:0] gate_sel,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [5:0] pass_mask,
  output logic       fail_valid,
  output logic [2:0] fail_gate,
  output logic [1:0] fail_vec
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_r;
  logic [2:0] gate_r;
  logic [1:0] vec_r;
  logic [3:0] cnt_r;
  logic       gate_ok_r;

  logic       match_s;
  logic       last_vec_s;
  logic       last_gate_s;
  logic       stop_s;
  logic [2:0] next_gate_s;
  logic [1:0] next_vec_s;
  logic [5:0] gate_bit_s;

  // Reference truth table, indexed by gate and the {a,b} vector.
  function automatic logic expected_bit(input logic [2:0] g, input logic [1:0] v);
    logic e;
    case (g)
      3'd0:    e = (v == 2'b11);
      3'd1:    e = (v != 2'b00);
      3'd2:    e = (v != 2'b11);
      3'd3:    e = (v == 2'b00);
      3'd4:    e = v[1] ^ v[0];
      3'd5:    e = ~(v[1] ^ v[0]);
      default: e = 1'b0;
    endcase
    return e;
  endfunction

  // Compare result and next-index arithmetic for the current vector.
  always_comb begin
    match_s     = (c == expected_bit(gate_r, vec_r));
    last_vec_s  = (vec_r == 2'd3);
    last_gate_s = (gate_r == 3'd5);
    gate_bit_s  = 6'b000001 << gate_r;
    next_vec_s  = vec_r + 2'd1;
    if (last_vec_s) begin
      next_gate_s = gate_r + 3'd1;
    end else begin
      next_gate_s = gate_r;
    end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    stop_s = ~match_s;
`else
    stop_s = 1'b0;
`endif
  end

  // Sweep FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      gate_r     <= 3'd0;
      vec_r      <= 2'd0;
      cnt_r      <= 4'd0;
      gate_ok_r  <= 1'b0;
      gate_sel   <= 3'd0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_mask  <= 6'd0;
      fail_valid <= 1'b0;
      fail_gate  <= 3'd0;
      fail_vec   <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done     <= 1'b0;
          gate_sel <= 3'd0;
          a        <= 1'b0;
          b        <= 1'b0;
          if (start) begin
            pass_mask  <= 6'd0;
            fail_valid <= 1'b0;
            fail_gate  <= 3'd0;
            fail_vec   <= 2'd0;
            gate_r     <= 3'd0;
            vec_r      <= 2'd0;
            gate_ok_r  <= 1'b1;
            busy       <= 1'b1;
            state_r    <= DRIVE;
          end else begin
            busy <= 1'b0;
          end
        end
        DRIVE: begin
          cnt_r   <= SETTLE_LOAD;
          state_r <= SETTLE;
        end
        SETTLE: begin
          if (cnt_r == 4'd0) begin
            state_r <= SAMPLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        SAMPLE: begin
          if (!match_s && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_gate  <= gate_r;
            fail_vec   <= vec_r;
          end
          if (last_vec_s && gate_ok_r && match_s) begin
            pass_mask <= pass_mask | gate_bit_s;
          end
          gate_ok_r <= last_vec_s ? 1'b1 : (gate_ok_r & match_s);
          if (stop_s || (last_vec_s && last_gate_s)) begin
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            // Inputs change on entry to DRIVE so they stay stable through SAMPLE.
            gate_r   <= next_gate_s;
            vec_r    <= next_vec_s;
            gate_sel <= next_gate_s;
            a        <= next_vec_s[1];
            b        <= next_vec_s[0];
            state_r  <= DRIVE;
          end
        end
        DONE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          gate_sel <= 3'd0;
          a        <= 1'b0;
          b        <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: table of sweeps on two instances (settle 4 and 1)
// plus hand sequences for held start and mid-sweep reset.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic c0, c1;
  logic [2:0] gate_sel0, gate_sel1, fail_gate0, fail_gate1;
  logic a0, a1, b0, b1, busy0, busy1, done0, done1, fail_valid0, fail_valid1;
  logic [5:0] pass_mask0, pass_mask1;
  logic [1:0] fail_vec0, fail_vec1;

  int checks = 0;
  int errors = 0;
  int cur = 0;
  int cyc = 0;
  bit fault = 1'b0;
  bit noise = 1'b0;

  always #5 clk = ~clk;

  gate_sweep_ctrl #(.SETTLE_CYCLES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .c(c0), .gate_sel(gate_sel0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .pass_mask(pass_mask0), .fail_valid(fail_valid0),
    .fail_gate(fail_gate0), .fail_vec(fail_vec0));

  gate_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .c(c1), .gate_sel(gate_sel1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .pass_mask(pass_mask1), .fail_valid(fail_valid1),
    .fail_gate(fail_gate1), .fail_vec(fail_vec1));

  function automatic logic gate_model(input logic [2:0] g, input logic x, input logic y);
    case (g)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return ~(x & y);
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      default: return 1'b0;
    endcase
  endfunction

  // Gate library models: optional XOR stuck-at-0, optional glitching during settle on dut1.
  always_comb begin
    c0 = gate_model(gate_sel0, a0, b0);
    if (fault && cur == 0 && gate_sel0 == 3'd4) c0 = 1'b0;
    c1 = gate_model(gate_sel1, a1, b1);
    if (fault && cur == 1 && gate_sel1 == 3'd4) c1 = 1'b0;
    if (noise && cur == 1 && (cyc % 3) == 2) c1 = ~c1;
  end

  logic       m_busy, m_done, m_fv;
  logic [5:0] m_mask;
  logic [2:0] m_fg;
  logic [1:0] m_fvec;
  assign m_busy = (cur == 1) ? busy1 : busy0;
  assign m_done = (cur == 1) ? done1 : done0;
  assign m_fv   = (cur == 1) ? fail_valid1 : fail_valid0;
  assign m_mask = (cur == 1) ? pass_mask1 : pass_mask0;
  assign m_fg   = (cur == 1) ? fail_gate1 : fail_gate0;
  assign m_fvec = (cur == 1) ? fail_vec1 : fail_vec0;

  typedef struct {
    string      name;
    int         inst;
    bit         fault;
    bit         noise;
    int         p1;
    int         p2;
    int         exp_done;
    logic [5:0] exp_mask;
    bit         exp_fv;
    logic [2:0] exp_fg;
    logic [1:0] exp_fvec;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 1) start1 = v;
    else start0 = v;
  endtask

  function automatic logic [18:0] all_out(input int inst);
    if (inst == 1)
      return {gate_sel1, a1, b1, busy1, done1, pass_mask1, fail_valid1, fail_gate1, fail_vec1};
    return {gate_sel0, a0, b0, busy0, done0, pass_mask0, fail_valid0, fail_gate0, fail_vec0};
  endfunction

  task automatic run_sweep(input vec_t v);
    int first_done, n_done, busy_bad;
    cur = v.inst; fault = v.fault; noise = v.noise; cyc = 0;
    @(negedge clk);
    set_start(v.inst, 1'b1);
    @(posedge clk);
    #1 set_start(v.inst, 1'b0);
    first_done = -1; n_done = 0; busy_bad = 0;
    for (int n = 1; n <= v.exp_done + 4; n++) begin
      @(negedge clk);
      cyc = n;
      if (m_done) begin
        n_done++;
        if (first_done < 0) first_done = n;
      end
      if (m_busy != (n <= v.exp_done)) busy_bad++;
      set_start(v.inst, (n == v.p1 || n == v.p2));
    end
    set_start(v.inst, 1'b0);
    check({v.name, ".done_cycle"}, first_done, v.exp_done);
    check({v.name, ".done_count"}, n_done, 1);
    check({v.name, ".busy_bad_cycles"}, busy_bad, 0);
    check({v.name, ".pass_mask"}, int'(m_mask), int'(v.exp_mask));
    check({v.name, ".fail_valid"}, int'(m_fv), int'(v.exp_fv));
    check({v.name, ".fail_gate"}, int'(m_fg), int'(v.exp_fg));
    check({v.name, ".fail_vec"}, int'(m_fvec), int'(v.exp_fvec));
    fault = 1'b0; noise = 1'b0;
  endtask

  initial begin
    int d1, d2, nd, busy_gap;
    tbl[0] = '{"ideal_s4", 0, 1'b0, 1'b0, -1, -1, 145, 6'h3F, 1'b0, 3'd0, 2'b00};
    tbl[2] = '{"ideal_s1_noise", 1, 1'b0, 1'b1, -1, -1, 73, 6'h3F, 1'b0, 3'd0, 2'b00};
    tbl[4] = '{"start_ignored", 0, 1'b0, 1'b0, 10, 50, 145, 6'h3F, 1'b0, 3'd0, 2'b00};
    tbl[5] = '{"ideal_s1", 1, 1'b0, 1'b0, -1, -1, 73, 6'h3F, 1'b0, 3'd0, 2'b00};
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    tbl[1] = '{"xor_stuck_s4", 0, 1'b1, 1'b0, -1, -1, 109, 6'h0F, 1'b1, 3'd4, 2'b01};
    tbl[3] = '{"xor_stuck_s1", 1, 1'b1, 1'b0, -1, -1, 55, 6'h0F, 1'b1, 3'd4, 2'b01};
`else
    tbl[1] = '{"xor_stuck_s4", 0, 1'b1, 1'b0, -1, -1, 145, 6'b101111, 1'b1, 3'd4, 2'b01};
    tbl[3] = '{"xor_stuck_s1", 1, 1'b1, 1'b0, -1, -1, 73, 6'b101111, 1'b1, 3'd4, 2'b01};
`endif

    repeat (2) @(negedge clk);
    check("reset.dut0_outputs", int'(all_out(0)), 0);
    check("reset.dut1_outputs", int'(all_out(1)), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_sweep(tbl[i]);

    // Start held high on dut1: the sweep restarts one idle cycle after DONE.
    cur = 1; cyc = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    d1 = -1; d2 = -1; nd = 0; busy_gap = -1;
    for (int n = 1; n <= 152; n++) begin
      @(negedge clk);
      if (done1) begin
        nd++;
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
      if (n == 74) busy_gap = int'(busy1);
      if (n == 100) start1 = 1'b0;
    end
    check("held_start.first_done", d1, 73);
    check("held_start.busy_gap", busy_gap, 0);
    check("held_start.second_done", d2, 147);
    check("held_start.done_count", nd, 2);
    check("held_start.idle_after", int'(busy1), 0);

    // Mid-sweep reset on dut0 with a faulty XOR: everything clears at once.
    cur = 0; fault = 1'b1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    for (int n = 1; n <= 60; n++) @(negedge clk);
    check("midreset.busy_before", int'(busy0), 1);
    check("midreset.mask_before", int'(pass_mask0), 6'h03);
    rst_n = 1'b0;
    #1;
    check("midreset.dut0_outputs", int'(all_out(0)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    fault = 1'b0;
    run_sweep(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
